// File: rtl/ps2_keyboard.sv
// Apple-1 PS/2 keyboard input: conditioned PS/2 receiver, Set-2 to ASCII decoder and PIA keyboard port.
// Define TYPEAHEAD_FIFO_EN to replace the single overwrite register with a FIFO_DEPTH type-ahead FIFO.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (strobe with data low)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | capturing the odd-parity bit
// RX_STOP   | checking stop bit and parity, emitting frame_valid
module ps2_keyboard #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 14318,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic       sys_clock,
   input  logic       reset,
   input  logic       cpu_clken,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       address,
   input  logic       r_en,
   output logic [7:0] dout,
   output logic       key_ready,
   output logic       reset_key
);

   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   logic             clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
   logic             clk_filt_q, clk_filt_d;
   logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
   logic             strobe;

   rx_state_t        rx_state_q, rx_state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_par_q, rx_par_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             frame_valid_q, frame_valid_d;
   logic [7:0]       frame_byte_q, frame_byte_d;

   logic             ext_q, ext_d, brk_q, brk_d;
   logic             shift_held_q, shift_held_d, ctrl_q, ctrl_d;
   logic             emit_q, emit_d;
   logic [6:0]       emit_char_q, emit_char_d;
   logic             reset_key_q, reset_key_d;
   logic [8:0]       key_map;

   logic             rd_clr;
   logic [6:0]       head_char;

   // Input conditioning: 2-FF synchronisers, then a stability filter on the clock
   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         clk_meta_q <= 1'b0;
         clk_sync_q <= 1'b0;
         dat_meta_q <= 1'b0;
         dat_sync_q <= 1'b0;
         clk_filt_q <= 1'b0;
         flt_cnt_q  <= FLT_W'(FILTER_LEN - 1);
      end else begin
         clk_meta_q <= ps2_clk;
         clk_sync_q <= clk_meta_q;
         dat_meta_q <= ps2_data;
         dat_sync_q <= dat_meta_q;
         clk_filt_q <= clk_filt_d;
         flt_cnt_q  <= flt_cnt_d;
      end
   end

   always_comb begin
      clk_filt_d = clk_filt_q;
      flt_cnt_d  = FLT_W'(FILTER_LEN - 1);
      if (clk_sync_q != clk_filt_q) begin
         if (flt_cnt_q == '0) begin
            clk_filt_d = clk_sync_q;
         end else begin
            flt_cnt_d = flt_cnt_q - FLT_W'(1);
         end
      end
   end

   assign strobe = clk_filt_q & ~clk_filt_d;

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         rx_state_q    <= RX_IDLE;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         rx_par_q      <= 1'b0;
         tmo_q         <= '0;
         frame_valid_q <= 1'b0;
         frame_byte_q  <= '0;
      end else begin
         rx_state_q    <= rx_state_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         rx_par_q      <= rx_par_d;
         tmo_q         <= tmo_d;
         frame_valid_q <= frame_valid_d;
         frame_byte_q  <= frame_byte_d;
      end
   end

   always_comb begin
      rx_state_d    = rx_state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      rx_par_d      = rx_par_q;
      tmo_d         = tmo_q;
      frame_valid_d = 1'b0;
      frame_byte_d  = frame_byte_q;
      if (strobe) begin
         tmo_d = TMO_W'(TIMEOUT_CYCLES - 1);
      end
      unique case (rx_state_q)
         RX_IDLE: begin
            if (strobe && !dat_sync_q) begin
               rx_state_d = RX_DATA;
               bit_cnt_d  = '0;
            end
         end
         RX_DATA: begin
            if (strobe) begin
               rx_shift_d = {dat_sync_q, rx_shift_q[7:1]};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_state_d = RX_PARITY;
               end
            end
         end
         RX_PARITY: begin
            if (strobe) begin
               rx_par_d   = dat_sync_q;
               rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (strobe) begin
               if (dat_sync_q && (^{rx_shift_q, rx_par_q})) begin
                  frame_valid_d = 1'b1;
                  frame_byte_d  = rx_shift_q;
               end
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
      // Abort a stalled frame once the down-counter expires without a strobe
      if ((rx_state_q != RX_IDLE) && !strobe) begin
         if (tmo_q == '0) begin
            rx_state_d = RX_IDLE;
         end else begin
            tmo_d = tmo_q - TMO_W'(1);
         end
      end
   end

   // Result: {mapped, is_letter, ascii[6:0]}
   function automatic logic [8:0] map_code(input logic [7:0] code, input logic shifted);
      logic [8:0] r;
      r = '0;
      case (code)
         8'h1C: r = {2'b11, 7'h41};
         8'h32: r = {2'b11, 7'h42};
         8'h21: r = {2'b11, 7'h43};
         8'h23: r = {2'b11, 7'h44};
         8'h24: r = {2'b11, 7'h45};
         8'h2B: r = {2'b11, 7'h46};
         8'h34: r = {2'b11, 7'h47};
         8'h33: r = {2'b11, 7'h48};
         8'h43: r = {2'b11, 7'h49};
         8'h3B: r = {2'b11, 7'h4A};
         8'h42: r = {2'b11, 7'h4B};
         8'h4B: r = {2'b11, 7'h4C};
         8'h3A: r = {2'b11, 7'h4D};
         8'h31: r = {2'b11, 7'h4E};
         8'h44: r = {2'b11, 7'h4F};
         8'h4D: r = {2'b11, 7'h50};
         8'h15: r = {2'b11, 7'h51};
         8'h2D: r = {2'b11, 7'h52};
         8'h1B: r = {2'b11, 7'h53};
         8'h2C: r = {2'b11, 7'h54};
         8'h3C: r = {2'b11, 7'h55};
         8'h2A: r = {2'b11, 7'h56};
         8'h1D: r = {2'b11, 7'h57};
         8'h22: r = {2'b11, 7'h58};
         8'h35: r = {2'b11, 7'h59};
         8'h1A: r = {2'b11, 7'h5A};
         8'h45: r = {2'b10, shifted ? 7'h29 : 7'h30};
         8'h16: r = {2'b10, shifted ? 7'h21 : 7'h31};
         8'h1E: r = {2'b10, shifted ? 7'h40 : 7'h32};
         8'h26: r = {2'b10, shifted ? 7'h23 : 7'h33};
         8'h25: r = {2'b10, shifted ? 7'h24 : 7'h34};
         8'h2E: r = {2'b10, shifted ? 7'h25 : 7'h35};
         8'h36: r = {2'b10, shifted ? 7'h5E : 7'h36};
         8'h3D: r = {2'b10, shifted ? 7'h26 : 7'h37};
         8'h3E: r = {2'b10, shifted ? 7'h2A : 7'h38};
         8'h46: r = {2'b10, shifted ? 7'h28 : 7'h39};
         8'h41: r = {2'b10, shifted ? 7'h3C : 7'h2C};
         8'h49: r = {2'b10, shifted ? 7'h3E : 7'h2E};
         8'h4A: r = {2'b10, shifted ? 7'h3F : 7'h2F};
         8'h4C: r = {2'b10, shifted ? 7'h3A : 7'h3B};
         8'h52: r = {2'b10, shifted ? 7'h22 : 7'h27};
         8'h4E: r = {2'b10, shifted ? 7'h5F : 7'h2D};
         8'h55: r = {2'b10, shifted ? 7'h2B : 7'h3D};
         8'h54: r = {2'b10, shifted ? 7'h7B : 7'h5B};
         8'h5B: r = {2'b10, shifted ? 7'h7D : 7'h5D};
         8'h5D: r = {2'b10, shifted ? 7'h7C : 7'h5C};
         8'h29: r = {2'b10, 7'h20};
         8'h5A: r = {2'b10, 7'h0D};
         8'h66: r = {2'b10, 7'h5F};
         8'h76: r = {2'b10, 7'h1B};
         default: r = '0;
      endcase
      return r;
   endfunction

   assign key_map = map_code(frame_byte_q, shift_held_q);

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         shift_held_q <= 1'b0;
         ctrl_q       <= 1'b0;
         emit_q       <= 1'b0;
         emit_char_q  <= '0;
         reset_key_q  <= 1'b0;
      end else begin
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         shift_held_q <= shift_held_d;
         ctrl_q       <= ctrl_d;
         emit_q       <= emit_d;
         emit_char_q  <= emit_char_d;
         reset_key_q  <= reset_key_d;
      end
   end

   always_comb begin
      ext_d        = ext_q;
      brk_d        = brk_q;
      shift_held_d = shift_held_q;
      ctrl_d       = ctrl_q;
      emit_d       = 1'b0;
      emit_char_d  = emit_char_q;
      reset_key_d  = 1'b0;
      if (frame_valid_q) begin
         if (frame_byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (frame_byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if ((frame_byte_q == 8'h12) || (frame_byte_q == 8'h59)) begin
               shift_held_d = ~brk_q;
            end else if (frame_byte_q == 8'h14) begin
               ctrl_d = ~brk_q;
            end else if (!brk_q) begin
               // Only keypad Enter survives the extended prefix
               if (ext_q) begin
                  if (frame_byte_q == 8'h5A) begin
                     emit_d      = 1'b1;
                     emit_char_d = 7'h0D;
                  end
               end else if (frame_byte_q == 8'h07) begin
                  reset_key_d = 1'b1;
               end else if (key_map[8]) begin
                  emit_d      = 1'b1;
                  emit_char_d = (key_map[7] && ctrl_q) ? (key_map[6:0] & 7'h1F) : key_map[6:0];
               end
            end
         end
      end
   end

   assign reset_key = reset_key_q;
   assign rd_clr    = cpu_clken & r_en & ~address;

`ifdef TYPEAHEAD_FIFO_EN
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [6:0]     fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
   logic           fifo_empty, fifo_full, fifo_push, fifo_pop;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == (PTR_W + 1)'(FIFO_DEPTH));
   assign fifo_pop   = rd_clr & ~fifo_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign fifo_push  = emit_q & (~fifo_full | fifo_pop);

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else begin
         if (fifo_push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= emit_char_q;
            wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
         end
         if (fifo_pop) begin
            rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
         end
      end
   end

   assign key_ready = ~fifo_empty;
   assign head_char = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
`else
   logic [6:0] char_q;
   logic       key_ready_q;

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         char_q      <= '0;
         key_ready_q <= 1'b0;
      end else if (emit_q) begin
         char_q      <= emit_char_q;
         key_ready_q <= 1'b1;
      end else if (rd_clr) begin
         key_ready_q <= 1'b0;
      end
   end

   assign key_ready = key_ready_q;
   assign head_char = char_q;
`endif

   always_comb begin
      dout = address ? {key_ready, 7'b0} : {1'b1, head_char};
   end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomised PS/2 keystroke bench for ps2_keyboard, checked against a table-driven keyboard model.
`timescale 1ns/1ps
module tb_ps2_keyboard;
   localparam int FLT = 4;
   localparam int TMO = 400;
   localparam int DEPTH = 8;

   logic       sys_clock = 1'b0;
   logic       reset, cpu_clken, ps2_clk, ps2_data, address, r_en;
   logic [7:0] dout;
   logic       key_ready, reset_key;

   always #5 sys_clock = ~sys_clock;

   ps2_keyboard #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
      .sys_clock(sys_clock), .reset(reset), .cpu_clken(cpu_clken),
      .ps2_clk(ps2_clk), .ps2_data(ps2_data), .address(address), .r_en(r_en),
      .dout(dout), .key_ready(key_ready), .reset_key(reset_key)
   );

   int n_chk = 0;
   int n_bad = 0;
   int rk_seen = 0;
   int rk_exp = 0;

   always @(negedge sys_clock) if (reset_key) rk_seen++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Keyboard model: US layout tables, modifier flags and the CPU-visible queue
   byte let_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                          8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                          8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   byte dig_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   byte pun_codes[10] = '{8'h41, 8'h49, 8'h4A, 8'h4C, 8'h52, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D};
   string dig_lo = "0123456789";
   string dig_hi = ")!@#$%^&*(";
   string pun_lo = ",./;'-=[]\\";
   string pun_hi = "<>?:\"_+{}|";
   byte pool[$];

   bit  m_shift, m_ctrl, m_brk, m_ext, m_ready;
   int  m_char;
   int  m_q[$];

   function automatic int lookup(byte code);
      for (int i = 0; i < 26; i++)
         if (let_codes[i] == code) return m_ctrl ? ((65 + i) % 32) : (65 + i);
      for (int i = 0; i < 10; i++)
         if (dig_codes[i] == code) return m_shift ? int'(dig_hi[i]) : int'(dig_lo[i]);
      for (int i = 0; i < 10; i++)
         if (pun_codes[i] == code) return m_shift ? int'(pun_hi[i]) : int'(pun_lo[i]);
      case (code)
         8'h29: return 32;
         8'h5A: return 13;
         8'h66: return 95;
         8'h76: return 27;
         default: return -1;
      endcase
   endfunction

   function automatic bit exp_ready();
`ifdef TYPEAHEAD_FIFO_EN
      return m_q.size() != 0;
`else
      return m_ready;
`endif
   endfunction

   function automatic int exp_head();
`ifdef TYPEAHEAD_FIFO_EN
      return (m_q.size() != 0) ? m_q[0] : 0;
`else
      return m_char;
`endif
   endfunction

   task automatic model_push(int c);
`ifdef TYPEAHEAD_FIFO_EN
      if (m_q.size() < DEPTH) m_q.push_back(c);
`else
      m_char = c;
      m_ready = 1'b1;
`endif
   endtask

   task automatic model_byte(byte code);
      bit rel;
      int c;
      if (code == 8'hE0) m_ext = 1'b1;
      else if (code == 8'hF0) m_brk = 1'b1;
      else begin
         rel = m_brk;
         if (code == 8'h12 || code == 8'h59) m_shift = !rel;
         else if (code == 8'h14) m_ctrl = !rel;
         else if (!rel) begin
            if (m_ext) begin
               if (code == 8'h5A) model_push(13);
            end else if (code == 8'h07) rk_exp++;
            else begin
               c = lookup(code);
               if (c >= 0) model_push(c);
            end
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic ps2_bit(bit b);
      ps2_data = b;
      repeat (10) @(negedge sys_clock);
      // Occasional glitch shorter than the filter window must be ignored
      if ($urandom_range(0, 3) == 0) begin
         ps2_clk = 1'b0;
         repeat (2) @(negedge sys_clock);
         ps2_clk = 1'b1;
      end else repeat (2) @(negedge sys_clock);
      repeat (6) @(negedge sys_clock);
      ps2_clk = 1'b0;
      repeat (20) @(negedge sys_clock);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(byte code, bit bad_par, bit bad_stop);
      bit p;
      p = ~(^code);
      if (bad_par) p = ~p;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(code[i]);
      ps2_bit(p);
      ps2_bit(!bad_stop);
      @(negedge sys_clock);
      ps2_data = 1'b1;
      repeat (8) @(negedge sys_clock);
   endtask

   task automatic check_state(string tag);
      bit er;
      er = exp_ready();
      chk({tag, ".rdy"}, key_ready, er);
      address = 1'b1;
      #1 chk({tag, ".a1"}, dout, {er, 7'b0});
`ifdef TYPEAHEAD_FIFO_EN
      address = 1'b0;
      if (er) #1 chk({tag, ".a0"}, dout, 8'h80 | exp_head());
`else
      address = 1'b0;
      #1 chk({tag, ".a0"}, dout, 8'h80 | exp_head());
`endif
      chk({tag, ".rk"}, rk_seen, rk_exp);
   endtask

   task automatic key(byte code);
      send_frame(code, 1'b0, 1'b0);
      model_byte(code);
      check_state("key");
   endtask

   task automatic do_read(bit ce);
      address = 1'b0;
      r_en = 1'b1;
      cpu_clken = ce;
      @(negedge sys_clock);
      r_en = 1'b0;
      cpu_clken = 1'b0;
      if (ce && exp_ready()) begin
`ifdef TYPEAHEAD_FIFO_EN
         void'(m_q.pop_front());
`else
         m_ready = 1'b0;
`endif
      end
   endtask

   task automatic read_chk(string tag, int want);
      address = 1'b0;
      #1 chk(tag, dout, want);
      do_read(1'b1);
   endtask

   initial begin
      int r;
      byte code;
      reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      address = 1'b1; r_en = 1'b0; cpu_clken = 1'b0;
      m_shift = 0; m_ctrl = 0; m_brk = 0; m_ext = 0; m_ready = 0; m_char = 0;
      foreach (let_codes[i]) pool.push_back(let_codes[i]);
      foreach (dig_codes[i]) pool.push_back(dig_codes[i]);
      foreach (pun_codes[i]) pool.push_back(pun_codes[i]);
      pool.push_back(8'h29); pool.push_back(8'h5A); pool.push_back(8'h66); pool.push_back(8'h76);
      pool.push_back(8'h12); pool.push_back(8'h59); pool.push_back(8'h14); pool.push_back(8'h07);
      pool.push_back(8'h05); pool.push_back(8'h0D); pool.push_back(8'h0E);

      repeat (3) @(negedge sys_clock);
      #1 chk("rst.rdy", key_ready, 1'b0);
      chk("rst.rk", reset_key, 1'b0);
      chk("rst.dout", dout, 8'h00);
      @(negedge sys_clock);
      reset = 1'b0;
      repeat (10) @(negedge sys_clock);

      key(8'h1C);
      address = 1'b0;
      #1 chk("t1.a0", dout, 8'hC1);
      address = 1'b1;
      #1 chk("t1.a1", dout, 8'h80);
      do_read(1'b1);
      address = 1'b1;
      #1 chk("t1.clr", dout, 8'h00);
      chk("t1.rdy", key_ready, 1'b0);

      key(8'h12); key(8'h16);
      read_chk("t2.bang", 8'hA1);
      key(8'hF0); key(8'h16);
      chk("t2.rel", key_ready, 1'b0);
      key(8'hF0); key(8'h12); key(8'h16);
      read_chk("t2.one", 8'hB1);
      chk("t2.cnt", key_ready, 1'b0);

      send_frame(8'h1C, 1'b1, 1'b0);
      check_state("t3.par");
      send_frame(8'h1C, 1'b0, 1'b1);
      check_state("t3.stop");

      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
      @(negedge sys_clock);
      ps2_data = 1'b1;
      repeat (TMO + 10) @(negedge sys_clock);
      check_state("t4.tmo");
      key(8'h5A);
      read_chk("t4.cr", 8'h8D);

      key(8'h14); key(8'h21);
      read_chk("t5.ctlc", 8'h83);
      key(8'hF0); key(8'h14);
      key(8'h1C);
      key(8'h07);
      chk("t5.rdy", key_ready, 1'b1);
      read_chk("t5.a", 8'hC1);

      for (int i = 0; i < 10; i++) key(let_codes[i]);
`ifdef TYPEAHEAD_FIFO_EN
      for (int i = 0; i < 8; i++) read_chk("t6.fifo", 8'hC1 + i);
`else
      read_chk("t6.last", 8'hCA);
`endif
      chk("t6.empty", key_ready, 1'b0);

      for (int it = 0; it < 70; it++) begin
         r = $urandom_range(0, 9);
         code = pool[$urandom_range(0, pool.size() - 1)];
         case (r)
            0, 1, 2, 3, 4: key(code);
            5: begin key(8'hF0); key(code); end
            6: begin
               key(8'hE0);
               case ($urandom_range(0, 3))
                  0: key(8'h5A);
                  1: key(8'h75);
                  2: key(8'h14);
                  default: key(code);
               endcase
            end
            7: begin
               if (exp_ready()) read_chk("rnd.rd", 8'h80 | exp_head());
               else begin do_read(1'b1); check_state("rnd.rd0"); end
            end
            8: begin do_read(1'b0); check_state("rnd.noce"); end
            default: begin
               send_frame(code, 1'b1, $urandom_range(0, 1) == 1);
               check_state("rnd.bad");
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
